// File: rtl/cpu_seq_pkg.sv
// Shared state encoding and strobe bundle for the instruction sequencer.
// Used by instr_sequencer (optional debug stepping under SEQ_DEBUG_STEP_EN).
package cpu_seq_pkg;

    localparam int unsigned SEQ_STATE_W = 3;
    localparam int unsigned INSTR_W     = 16;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_DBG_HALT  = 3'd7
    } seq_state_e;

    // Registered control strobes driven towards memories and datapath
    typedef struct packed {
        logic imem_req;
        logic dmem_req;
        logic dmem_we;
        logic pc_enb;
        logic rf_we;
        logic flags_we;
        logic halted;
    } seq_strobe_t;

    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles, flags when TIMEOUT_CYCLES is reached.
module seq_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expired_q;

    // Saturates at the limit; the sequencer leaves the wait state once expired
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_q) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == CW'(TIMEOUT_CYCLES));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM for the 16-bit core.
// Optional debug halt/step support is compiled in with SEQ_DEBUG_STEP_EN.
module instr_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    input  logic               is_alu,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               is_halt,
    input  logic               writes_reg,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               PC_enb,
    output logic               rf_we,
    output logic               flags_we,
    output logic               halted,
    output logic               bus_err,
    output logic [CNT_W-1:0]   instr_count
`ifdef SEQ_DEBUG_STEP_EN
    ,
    input  logic               dbg_halt_req,
    input  logic               dbg_step,
    output logic               dbg_halted
`endif
);

    seq_state_e         state_q;
    seq_state_e         state_d;
    seq_strobe_t        strb_q;
    seq_strobe_t        strb_d;
    logic [INSTR_W-1:0] instr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bus_err_q;
    logic               timeout_hit;
    logic               timer_clr;
    logic               timer_en;
    logic               timer_expired;

    // Stall counter restarts whenever the FSM changes state
    assign timer_clr = (state_d != state_q);
    assign timer_en  = is_wait_state(state_q) &&
                       !((state_q == ST_FETCH) ? imem_ack : dmem_ack);

    seq_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack arriving on the expiry cycle takes priority
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE:      state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d     = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_DECODE:    state_d = is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = (is_load || is_store) ? ST_MEM : ST_WRITEBACK;
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WRITEBACK;
                end else if (timer_expired) begin
                    state_d     = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
`ifdef SEQ_DEBUG_STEP_EN
                if (dbg_halt_req) begin
                    state_d = ST_DBG_HALT;
                end
`endif
            end
            ST_HALT:      state_d = ST_HALT;
            ST_DBG_HALT: begin
`ifdef SEQ_DEBUG_STEP_EN
                if (dbg_step || !dbg_halt_req) begin
                    state_d = ST_FETCH;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    // Strobes decoded from the upcoming state so they register in step with it
    always_comb begin
        strb_d = '0;
        unique case (state_d)
            ST_FETCH:     strb_d.imem_req = 1'b1;
            ST_EXECUTE:   strb_d.flags_we = is_alu;
            ST_MEM: begin
                strb_d.dmem_req = 1'b1;
                strb_d.dmem_we  = is_store;
            end
            ST_WRITEBACK: begin
                strb_d.pc_enb = 1'b1;
                strb_d.rf_we  = writes_reg;
            end
            ST_HALT:      strb_d.halted = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            strb_q    <= '0;
            instr_q   <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            strb_q <= strb_d;
            if ((state_q == ST_FETCH) && imem_ack) begin
                instr_q <= imem_rdata;
            end
            if (state_d == ST_WRITEBACK) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

`ifdef SEQ_DEBUG_STEP_EN
    logic dbg_halted_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dbg_halted_q <= 1'b0;
        end else begin
            dbg_halted_q <= (state_d == ST_DBG_HALT);
        end
    end

    assign dbg_halted = dbg_halted_q;
`endif

    assign imem_req    = strb_q.imem_req;
    assign dmem_req    = strb_q.dmem_req;
    assign dmem_we     = strb_q.dmem_we;
    assign PC_enb      = strb_q.pc_enb;
    assign rf_we       = strb_q.rf_we;
    assign flags_we    = strb_q.flags_we;
    assign halted      = strb_q.halted;
    assign instr       = instr_q;
    assign instr_count = cnt_q;
    assign bus_err     = bus_err_q;

endmodule
